// File: rtl/column_cfg_pkg.sv
// Shared constants, loader states and sizing helper for the
// column configuration loader.
package column_cfg_pkg;

  localparam int TILE_CONFIG_WIDTH   = 146;
  localparam int TILES_PER_COLUMN    = 3;
  localparam int COLUMN_CONFIG_WIDTH =
    TILE_CONFIG_WIDTH * TILES_PER_COLUMN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_RELEASE,
    ST_DONE
  } loader_state_t;

  function automatic int num_words(
    input int width,
    input int word
  );
    return (width + word - 1) / word;
  endfunction

endpackage

// File: rtl/column_config_loader_assembler.sv
// Shadow register fed one stream word at a time; the final word
// is truncated to the bits that remain in the column config.
module cfg_word_assembler
  import column_cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = COLUMN_CONFIG_WIDTH,
  parameter int WORD_WIDTH   = 8,
  parameter int NUM_WORDS    = 55,
  parameter int CW           = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    wr_i,
  input  logic [WORD_WIDTH-1:0]   data_i,
  output logic [CONFIG_WIDTH-1:0] shadow_o,
  output logic [CW-1:0]           count_o,
  output logic                    last_o
);

  localparam logic [CONFIG_WIDTH-1:0] LANE =
    CONFIG_WIDTH'({WORD_WIDTH{1'b1}});

  logic [CONFIG_WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]           count_q, count_d;
  logic [31:0]             shamt;

  assign shamt = 32'(count_q) * 32'(WORD_WIDTH);

  // Shifting past the top drops the unused bits of the last word.
  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    if (clear_i) begin
      shadow_d = '0;
      count_d  = '0;
    end else if (wr_i) begin
      shadow_d = (shadow_q & ~(LANE << shamt))
               | (CONFIG_WIDTH'(data_i) << shamt);
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign shadow_o = shadow_q;
  assign count_o  = count_q;
  assign last_o   = wr_i && !clear_i
                 && (count_q == CW'(NUM_WORDS - 1));

endmodule

// File: rtl/column_config_loader.sv
// Streams a column config into a shadow, commits it in one edge
// and sequences the column's active-low fabric reset.
module column_config_loader
  import column_cfg_pkg::*;
#(
  parameter int CONFIG_WIDTH = COLUMN_CONFIG_WIDTH,
  parameter int WORD_WIDTH   = 8,
  parameter int RESET_HOLD   = 4,
  localparam int NUM_WORDS   =
    num_words(CONFIG_WIDTH, WORD_WIDTH),
  localparam int CW          = $clog2(NUM_WORDS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   cfg_data,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    fabric_nreset,
  output logic                    busy,
  output logic                    done,
  output logic [CW-1:0]           word_count
);

  localparam int HW = $clog2(RESET_HOLD + 1);

  loader_state_t           state_q, state_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [CONFIG_WIDTH-1:0] config_q, config_d;
  logic                    nreset_q, nreset_d;
  logic                    clear;
  logic                    last;
  logic [CONFIG_WIDTH-1:0] shadow;

  cfg_word_assembler #(
    .CONFIG_WIDTH (CONFIG_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH),
    .NUM_WORDS    (NUM_WORDS),
    .CW           (CW)
  ) u_asm (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (clear),
    .wr_i     (cfg_valid && cfg_ready),
    .data_i   (cfg_data),
    .shadow_o (shadow),
    .count_o  (word_count),
    .last_o   (last)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    config_d = config_q;
    nreset_d = nreset_q;
    clear    = 1'b0;
    // A start from any state wins over everything else.
    if (start) begin
      state_d  = ST_LOAD;
      clear    = 1'b1;
      nreset_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (last) state_d = ST_COMMIT;
        end
        ST_COMMIT: begin
          config_d = shadow;
          hold_d   = HW'(RESET_HOLD - 1);
          state_d  = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (hold_q == '0) begin
            state_d  = ST_DONE;
            nreset_d = 1'b1;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      config_q <= '0;
      nreset_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      config_q <= config_d;
      nreset_q <= nreset_d;
    end
  end

  assign cfg_ready     = (state_q == ST_LOAD);
  assign busy          = (state_q == ST_LOAD)
                      || (state_q == ST_COMMIT)
                      || (state_q == ST_RELEASE);
  assign done          = (state_q == ST_DONE);
  assign config_out    = config_q;
  assign fabric_nreset = nreset_q;

endmodule
